inst_rom_loader: RTL
====================

// Module: inst_rom_loader
// PURPOSE
//   Responder end of the core's instruction-fetch port: serves rom_addr/rom_ce with same-cycle read data.
//   Adds a byte-serial load path (e.g. from a UART receiver) that fills the instruction store while holding the core in reset.
//   Sits beside the riscv core at FPGA top level; cpu_rst_n_o drives the core's rst_n.
// PARAMETERS
//   AW      8      log2 of store depth in 32-bit words (256 words)
//   NOP     32'h0000_0013  word returned for out-of-range fetches (addi x0,x0,0)
// PORTS
//   clk          in   1    system clock
//   rst_n        in   1    asynchronous active-low reset
//   rom_ce_i     in   1    fetch enable from core
//   rom_addr_i   in   32   byte address (pc) from core
//   rom_data_o   out  32   instruction word, combinational from rom_addr_i
//   ld_start     in   1    pulse: begin a new image load
//   ld_valid     in   1    ld_byte valid this cycle
//   ld_byte      in   8    image byte, little-endian within each word
//   ld_end       in   1    pulse: image complete
//   cpu_rst_n_o  out  1    reset to core; low while loading
//   ld_busy      out  1    high in LOAD state
//   ld_words     out  AW+1 words written by last/current load
//   ld_ovf       out  1    sticky: bytes dropped because store full
// BEHAVIOUR
//   Reset (async, rst_n=0): state=RUN, byte_cnt=0, wr_ptr=0, word_buf=0, ld_words=0, ld_ovf=0.
//     Store array is NOT reset; contents survive reset. cpu_rst_n_o=0 while rst_n=0.
//   cpu_rst_n_o = rst_n & (state==RUN), registered-free combinational AND.
//   States: RUN, LOAD.
//     RUN:  ld_start -> LOAD; wr_ptr,byte_cnt,ld_words,ld_ovf cleared. ld_valid/ld_end ignored.
//     LOAD: ld_valid: word_buf[8*byte_cnt +: 8]<=ld_byte, byte_cnt<=byte_cnt+1 (2-bit wrap).
//           byte_cnt==3 & ld_valid: mem[wr_ptr]<={ld_byte,word_buf[23:0]}, wr_ptr++, ld_words++, word_buf<=0.
//           ld_end: if byte_cnt!=0 (after this cycle's byte) flush word_buf zero-padded to mem[wr_ptr], ld_words++; -> RUN.
//           ld_start in LOAD: restart (same as RUN->LOAD); in-flight partial word discarded.
//   Simultaneous: ld_start+ld_valid -> restart, byte stored as lane 0 of word 0.
//     ld_valid+ld_end -> byte accepted first, then flush, then RUN. ld_start beats ld_end.
//   Full: wr_ptr width AW+1; when wr_ptr==2**AW, further bytes dropped, ld_ovf<=1 (sticky until next ld_start); no wrap.
//   Fetch: index = rom_addr_i[AW+1:2]; rom_addr_i[1:0] ignored.
//     rom_data_o = 0 if !rom_ce_i; NOP if rom_addr_i[31:AW+2]!=0; else mem[index].
//     Fetch is valid in any state; core is held in reset during LOAD so fetches are don't-care there.
//   Write-then-read same word: read in the write cycle returns old data; new data the next cycle.
//   Reset mid-load: state->RUN, partial word lost, fully written words remain; ld_words reads 0.
//   Latency: word written on the clock edge of its 4th byte; core released the cycle after ld_end.
// STRUCTURE
//   Shared package: state encoding (ST_RUN, ST_LOAD), NOP constant, ROM width/depth constants used by core top.
//   Sub-module: inst_mem_sdp (one write port, one asynchronous read port, no reset) -> distributed RAM.
//   FSM, byte assembler and write pointer stay in this module.
// TESTING
//   Reset then ld_start, bytes 13 00 00 00 93 00 10 00, ld_end -> mem[0]=00000013, mem[1]=00100093, ld_words=2.
//   Load 6 bytes 01 02 03 04 05 06 + ld_end -> mem[1]=00000605 (zero-padded), ld_words=2, cpu_rst_n_o rises next cycle.
//   Fetch rom_ce_i=1, rom_addr_i=4 -> 00100093; addr=7 -> same word; rom_ce_i=0 -> 0; addr=32'h400 (AW=8) -> 00000013.
//   Load 4*256+4 bytes -> 256 words written, ld_ovf=1, last 4 bytes dropped, mem[0] unchanged by overflow.
//   ld_start coincident with ld_valid byte AA, then BB CC DD -> mem[0]=DDCCBBAA; ld_start mid-word restarts at lane 0.
//   rst_n pulsed low after 2 bytes of word 3 -> state RUN, cpu_rst_n_o follows rst_n, mem[0..2] intact, ld_words=0.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared constants and state encoding for the instruction store and its byte-serial loader.
package inst_rom_loader_pkg;
  localparam int          ROM_AW  = 8;
  localparam int          ROM_DW  = 32;
  localparam logic [31:0] ROM_NOP = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } ld_state_e;
endpackage

// File: rtl/inst_mem_sdp.sv
// Simple dual-port store: one synchronous write port, one asynchronous read port, no reset.
module inst_mem_sdp #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_rom_loader.sv
// Instruction-fetch responder with a byte-serial image loader that holds the core in reset while loading.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int          AW  = ROM_AW,
  parameter logic [31:0] NOP = ROM_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_end,
  output logic        cpu_rst_n_o,
  output logic        ld_busy,
  output logic [AW:0] ld_words,
  output logic        ld_ovf
);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  ld_state_e       state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d, asm_cnt;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [31:0]     word_buf_q, word_buf_d, asm_buf;
  logic            ld_ovf_q, ld_ovf_d;
  logic            full, mem_we;
  logic [31:0]     rd_word;
  logic [1:0]      unused_addr_lsb;

  assign full = (wr_ptr_q == FULL);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    word_buf_d = word_buf_q;
    ld_ovf_d   = ld_ovf_q;
    mem_we     = 1'b0;
    asm_buf    = word_buf_q;
    asm_cnt    = byte_cnt_q;
    if (ld_start) begin
      state_d    = ST_LOAD;
      wr_ptr_d   = '0;
      ld_ovf_d   = 1'b0;
      byte_cnt_d = ld_valid ? 2'd1 : 2'd0;
      word_buf_d = ld_valid ? {24'h0, ld_byte} : 32'h0;
    end else if (state_q == ST_LOAD) begin
      if (ld_valid && full) ld_ovf_d = 1'b1;
      if (ld_valid && !full) begin
        asm_buf[8*byte_cnt_q +: 8] = ld_byte;
        asm_cnt = byte_cnt_q + 2'd1;
      end
      // A completed word and an end-of-image tail never coincide: the 4th byte wraps asm_cnt to 0.
      if ((ld_valid && !full && byte_cnt_q == 2'd3) || (ld_end && asm_cnt != 2'd0)) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      byte_cnt_d = mem_we ? 2'd0 : asm_cnt;
      word_buf_d = mem_we ? 32'h0 : asm_buf;
      if (ld_end) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= ST_RUN;
      byte_cnt_q <= '0;
      wr_ptr_q   <= '0;
      word_buf_q <= '0;
      ld_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      word_buf_q <= word_buf_d;
      ld_ovf_q   <= ld_ovf_d;
    end

  inst_mem_sdp #(.AW(AW), .DW(ROM_DW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (asm_buf),
    .raddr (rom_addr_i[AW+1:2]),
    .rdata (rd_word)
  );

  assign unused_addr_lsb = rom_addr_i[1:0];
  assign rom_data_o  = !rom_ce_i ? 32'h0 : (|rom_addr_i[31:AW+2]) ? NOP : rd_word;
  assign cpu_rst_n_o = rst_n & (state_q == ST_RUN);
  assign ld_busy     = (state_q == ST_LOAD);
  // Every write advances the pointer, so the pointer is the word count.
  assign ld_words    = wr_ptr_q;
  assign ld_ovf      = ld_ovf_q;
endmodule
